// File: rtl/msg_asm_pkg.sv
// Shared definitions for the CRC front-end nibble assembler.
// Holds the FSM state type, frame geometry and the payload masks applied in
// generate mode when the optional masking feature is built in.
package msg_asm_pkg;

  localparam int unsigned MSG_W      = 60;
  localparam int unsigned NIB_NUM    = 15;
  localparam int unsigned PAY_W_CRC8 = 52;
  localparam int unsigned PAY_W_CRC5 = 55;

  // Keep only the payload bits; the bits above are reserved for the CRC field.
  localparam logic [MSG_W-1:0] MASK_CRC8 =
      {{(MSG_W - PAY_W_CRC8){1'b0}}, {PAY_W_CRC8{1'b1}}};
  localparam logic [MSG_W-1:0] MASK_CRC5 =
      {{(MSG_W - PAY_W_CRC5){1'b0}}, {PAY_W_CRC5{1'b1}}};

  typedef enum logic [1:0] {
    StIdle,
    StCollect,
    StEmit,
    StHold
  } state_e;

  // Check mode passes the frame untouched; generate mode clears the CRC field.
  function automatic logic [MSG_W-1:0] mask_msg(input logic [MSG_W-1:0] msg,
                                                input logic             mode,
                                                input logic             crc);
    if (mode) begin
      return msg;
    end
    return msg & (crc ? MASK_CRC5 : MASK_CRC8);
  endfunction

endpackage

// File: rtl/msg_nibble_assembler_if.sv
// Nibble stream interface feeding the message assembler.
//   s_valid : beat valid (source)
//   s_ready : sink can accept a beat (sink)
//   s_first : beat is nibble 0 of a frame (source)
//   s_data  : 4-bit nibble payload (source)
//   s_mode  : 0 = generate, 1 = check; meaningful on s_first beats (source)
//   s_crc   : 0 = CRC-8, 1 = CRC-5; meaningful on s_first beats (source)
interface msg_nibble_assembler_if;
  logic       s_valid;
  logic       s_ready;
  logic       s_first;
  logic [3:0] s_data;
  logic       s_mode;
  logic       s_crc;

  modport master (
    output s_valid,
    output s_first,
    output s_data,
    output s_mode,
    output s_crc,
    input  s_ready
  );

  modport slave (
    input  s_valid,
    input  s_first,
    input  s_data,
    input  s_mode,
    input  s_crc,
    output s_ready
  );
endinterface

// File: rtl/msg_nibble_assembler.sv
// Front end of the CRC pipeline: collects a 60-bit message as 15 nibbles,
// MSB nibble first, emits it as a one-cycle in_valid pulse and then holds
// off the source for HOLDOFF cycles so the downstream pipeline cannot be
// overrun.
//
// Parameters:
//   HOLDOFF  : cycles s_ready stays low after the emit cycle (1..255)
// Ports:
//   clk_1    : sole clock, rising edge
//   rst      : synchronous active-high reset
//   s        : nibble stream (slave side of msg_nibble_assembler_if)
//   in_valid : one-cycle frame-ready pulse
//   message  : assembled frame, 0 outside the in_valid cycle
//   mode     : frame mode, 0 outside the in_valid cycle
//   CRC      : frame CRC select, 0 outside the in_valid cycle
//   err      : one-cycle protocol error pulse (orphan or restart beat)
// Build option:
//   MSG_ASM_MASK_EN : when defined, generate-mode frames have the bits above
//                     the payload width cleared at emit.
module msg_nibble_assembler
  import msg_asm_pkg::*;
#(
  parameter int unsigned HOLDOFF = 8
) (
  input  logic                   clk_1,
  input  logic                   rst,
  msg_nibble_assembler_if.slave  s,
  output logic                   in_valid,
  output logic [MSG_W-1:0]       message,
  output logic                   mode,
  output logic                   CRC,
  output logic                   err
);

  state_e           r_state, w_state_nxt;
  logic [3:0]       r_cnt, w_cnt_nxt;
  logic [7:0]       r_hold, w_hold_nxt;
  logic [MSG_W-1:0] r_msg, w_msg_nxt;
  logic             r_mode, w_mode_nxt;
  logic             r_crc, w_crc_nxt;
  logic             r_err, w_err_nxt;
  logic             r_ready, w_ready_nxt;
  logic             w_accept;
  logic             w_emit;
  logic [MSG_W-1:0] w_frame;

  assign w_accept = s.s_valid && r_ready;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_hold_nxt  = r_hold;
    w_msg_nxt   = r_msg;
    w_mode_nxt  = r_mode;
    w_crc_nxt   = r_crc;
    w_err_nxt   = 1'b0;

    unique case (r_state)
      StIdle: begin
        if (w_accept) begin
          if (s.s_first) begin
            w_msg_nxt   = {s.s_data, {(MSG_W - 4){1'b0}}};
            w_mode_nxt  = s.s_mode;
            w_crc_nxt   = s.s_crc;
            w_cnt_nxt   = 4'd1;
            w_state_nxt = StCollect;
          end else begin
            w_err_nxt = 1'b1;
          end
        end
      end

      StCollect: begin
        if (w_accept) begin
          if (s.s_first) begin
            // Restart: the partial frame is discarded, this beat is nibble 0.
            w_msg_nxt  = {s.s_data, {(MSG_W - 4){1'b0}}};
            w_mode_nxt = s.s_mode;
            w_crc_nxt  = s.s_crc;
            w_cnt_nxt  = 4'd1;
            w_err_nxt  = 1'b1;
          end else begin
            for (int k = 1; k < NIB_NUM; k++) begin
              if (r_cnt == 4'(k)) begin
                w_msg_nxt[MSG_W-1-4*k -: 4] = s.s_data;
              end
            end
            w_cnt_nxt = r_cnt + 4'd1;
            if (r_cnt == 4'(NIB_NUM - 1)) begin
              w_cnt_nxt   = 4'd0;
              w_state_nxt = StEmit;
            end
          end
        end
      end

      StEmit: begin
        w_hold_nxt  = 8'(HOLDOFF);
        w_state_nxt = StHold;
      end

      StHold: begin
        w_hold_nxt = r_hold - 8'd1;
        // Leave when the count reaches zero; the <= also guards HOLDOFF = 0.
        if (r_hold <= 8'd1) begin
          w_hold_nxt  = 8'd0;
          w_state_nxt = StIdle;
        end
      end

      default: begin
        w_state_nxt = StIdle;
      end
    endcase

    w_ready_nxt = (w_state_nxt == StIdle) || (w_state_nxt == StCollect);
  end

  always_ff @(posedge clk_1) begin
    if (rst) begin
      r_state <= StIdle;
      r_cnt   <= 4'd0;
      r_hold  <= 8'd0;
      r_msg   <= '0;
      r_mode  <= 1'b0;
      r_crc   <= 1'b0;
      r_err   <= 1'b0;
      r_ready <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_hold  <= w_hold_nxt;
      r_msg   <= w_msg_nxt;
      r_mode  <= w_mode_nxt;
      r_crc   <= w_crc_nxt;
      r_err   <= w_err_nxt;
      r_ready <= w_ready_nxt;
    end
  end

`ifdef MSG_ASM_MASK_EN
  assign w_frame = mask_msg(r_msg, r_mode, r_crc);
`else
  assign w_frame = r_msg;
`endif

  assign w_emit    = (r_state == StEmit);
  assign in_valid  = w_emit;
  assign message   = w_emit ? w_frame : '0;
  assign mode      = w_emit & r_mode;
  assign CRC       = w_emit & r_crc;
  assign err       = r_err;
  assign s.s_ready = r_ready;

endmodule

// File: tb/tb_msg_nibble_assembler.sv
// Directed bench for msg_nibble_assembler: table of frames sent back to back
// with holdoff and frame-period checks, plus restart, orphan-beat and
// mid-frame reset sequences.
module tb_msg_nibble_assembler;

  logic        clk_1 = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [59:0] message;
  logic        mode;
  logic        CRC;
  logic        err;

  msg_nibble_assembler_if bus ();

  msg_nibble_assembler #(
    .HOLDOFF (8)
  ) dut (
    .clk_1    (clk_1),
    .rst      (rst),
    .s        (bus),
    .in_valid (in_valid),
    .message  (message),
    .mode     (mode),
    .CRC      (CRC),
    .err      (err)
  );

  always #5 clk_1 = ~clk_1;

  typedef struct {
    logic [59:0] msg;
    logic        mode;
    logic        crc;
    logic [59:0] exp_mask;
  } vec_t;

  localparam int NVEC = 6;
  vec_t vecs [NVEC];

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  task automatic tick;
    @(posedge clk_1);
    #1;
    cyc++;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [3:0] nib(input logic [59:0] msg, input int k);
    logic [59:0] sh;
    sh = msg >> (4 * (14 - k));
    return sh[3:0];
  endfunction

  function automatic logic [59:0] expect_msg(input vec_t v);
`ifdef MSG_ASM_MASK_EN
    return v.exp_mask;
`else
    return v.msg;
`endif
  endfunction

  // Non-first beats carry inverted mode/crc so only nibble 0 may be sampled.
  task automatic set_beat(input logic [59:0] msg, input int k, input logic m, input logic c);
    bus.s_valid = 1'b1;
    bus.s_first = (k == 0);
    bus.s_data  = nib(msg, k);
    bus.s_mode  = (k == 0) ? m : ~m;
    bus.s_crc   = (k == 0) ? c : ~c;
  endtask

  task automatic idle_inputs;
    bus.s_valid = 1'b0;
    bus.s_first = 1'b0;
    bus.s_data  = 4'h0;
    bus.s_mode  = 1'b0;
    bus.s_crc   = 1'b0;
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (!bus.s_ready && n < 40) begin
      tick;
      n++;
    end
    check("wait_ready", 64'(bus.s_ready), 64'd1);
  endtask

  task automatic check_emit(input string tag, input logic [59:0] exp_msg, input logic m,
                            input logic c);
    check({tag, "_in_valid"}, 64'(in_valid), 64'd1);
    check({tag, "_message"}, 64'(message), 64'(exp_msg));
    check({tag, "_mode"}, 64'(mode), 64'(m));
    check({tag, "_crc"}, 64'(CRC), 64'(c));
    check({tag, "_err"}, 64'(err), 64'd0);
  endtask

  task automatic send_frame(input string tag, input vec_t v);
    int n;
    wait_ready(n);
    for (int k = 0; k < 15; k++) begin
      set_beat(v.msg, k, v.mode, v.crc);
      tick;
      if (k < 14) check({tag, "_no_early_valid"}, 64'(in_valid), 64'd0);
    end
    idle_inputs();
    check_emit(tag, expect_msg(v), v.mode, v.crc);
  endtask

  initial begin
    int n;
    int t_prev;
    int seen;
    vec_t va;

    vecs[0] = '{60'h123456789ABCDEF, 1'b0, 1'b0, 60'h003456789ABCDEF};
    vecs[1] = '{60'h123456789ABCDEF, 1'b0, 1'b1, 60'h023456789ABCDEF};
    vecs[2] = '{60'h123456789ABCDEF, 1'b1, 1'b0, 60'h123456789ABCDEF};
    vecs[3] = '{60'hFFFFFFFFFFFFFFF, 1'b0, 1'b1, 60'h07FFFFFFFFFFFFF};
    vecs[4] = '{60'hFFFFFFFFFFFFFFF, 1'b0, 1'b0, 60'h00FFFFFFFFFFFFF};
    vecs[5] = '{60'hFEDCBA987654321, 1'b1, 1'b1, 60'hFEDCBA987654321};
    t_prev = 0;

    rst = 1'b1;
    idle_inputs();
    repeat (3) tick;
    check("rst_s_ready", 64'(bus.s_ready), 64'd0);
    check("rst_in_valid", 64'(in_valid), 64'd0);
    check("rst_message", 64'(message), 64'd0);
    check("rst_mode", 64'(mode), 64'd0);
    check("rst_crc", 64'(CRC), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    rst = 1'b0;
    tick;
    check("ready_after_reset", 64'(bus.s_ready), 64'd1);

    // Back-to-back frames with s_valid held high through the holdoff window.
    for (int i = 0; i < NVEC; i++) begin
      set_beat(vecs[i].msg, 0, vecs[i].mode, vecs[i].crc);
      wait_ready(n);
      if (i > 0) check("holdoff_after_emit", 64'(n), 64'd8);
      for (int k = 0; k < 15; k++) begin
        set_beat(vecs[i].msg, k, vecs[i].mode, vecs[i].crc);
        tick;
        if (k < 14) check("vec_no_early_valid", 64'(in_valid), 64'd0);
      end
      check_emit("vec", expect_msg(vecs[i]), vecs[i].mode, vecs[i].crc);
      if (i > 0) check("frame_period", 64'(cyc - t_prev), 64'd24);
      t_prev = cyc;
      if (i < NVEC - 1) set_beat(vecs[i+1].msg, 0, vecs[i+1].mode, vecs[i+1].crc);
      else idle_inputs();
      tick;
      check("emit_ready_low", 64'(bus.s_ready), 64'd0);
      check("post_emit_valid", 64'(in_valid), 64'd0);
      check("post_emit_message", 64'(message), 64'd0);
      check("post_emit_mode", 64'(mode), 64'd0);
      check("post_emit_crc", 64'(CRC), 64'd0);
    end

    // Restart at nibble 7 with an all-0xA frame.
    idle_inputs();
    wait_ready(n);
    for (int k = 0; k < 7; k++) begin
      set_beat(vecs[0].msg, k, 1'b0, 1'b0);
      tick;
    end
    va = '{60'hAAAAAAAAAAAAAAA, 1'b1, 1'b1, 60'hAAAAAAAAAAAAAAA};
    set_beat(va.msg, 0, 1'b1, 1'b1);
    tick;
    check("restart_err", 64'(err), 64'd1);
    check("restart_ready", 64'(bus.s_ready), 64'd1);
    for (int j = 1; j < 15; j++) begin
      set_beat(va.msg, j, 1'b1, 1'b1);
      tick;
      if (j == 1) check("restart_err_one_cycle", 64'(err), 64'd0);
      if (j < 14) check("restart_no_early_valid", 64'(in_valid), 64'd0);
    end
    idle_inputs();
    check_emit("restart", va.msg, 1'b1, 1'b1);

    // Orphan beat in IDLE.
    wait_ready(n);
    bus.s_valid = 1'b1;
    bus.s_first = 1'b0;
    bus.s_data  = 4'h5;
    tick;
    idle_inputs();
    check("orphan_err", 64'(err), 64'd1);
    check("orphan_ready", 64'(bus.s_ready), 64'd1);
    tick;
    check("orphan_err_one_cycle", 64'(err), 64'd0);
    check("orphan_no_valid", 64'(in_valid), 64'd0);

    // Reset during nibble 10, then a clean frame.
    for (int k = 0; k < 10; k++) begin
      set_beat(vecs[5].msg, k, vecs[5].mode, vecs[5].crc);
      tick;
    end
    set_beat(vecs[5].msg, 10, vecs[5].mode, vecs[5].crc);
    rst = 1'b1;
    tick;
    check("midrst_in_valid", 64'(in_valid), 64'd0);
    check("midrst_message", 64'(message), 64'd0);
    check("midrst_mode", 64'(mode), 64'd0);
    check("midrst_crc", 64'(CRC), 64'd0);
    check("midrst_err", 64'(err), 64'd0);
    check("midrst_ready", 64'(bus.s_ready), 64'd0);
    rst = 1'b0;
    idle_inputs();
    seen = 0;
    for (int t = 0; t < 30; t++) begin
      tick;
      if (in_valid) seen++;
    end
    check("midrst_no_emit", 64'(seen), 64'd0);
    send_frame("after_rst", vecs[0]);
    tick;
    check("after_rst_single_pulse", 64'(in_valid), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
